// File: rtl/bus_xfer_ctrl_if.sv
// Command/strobe bundle between the move requesters and the bus sequencer.
// The slave side is the sequencer; the master side is the command source.
interface bus_xfer_ctrl_if #(
    parameter int N_REG = 2,
    parameter int IDX_W = 1
);
    logic             req0_valid;
    logic [IDX_W-1:0] req0_src;
    logic [IDX_W-1:0] req0_dst;
    logic             req0_ready;
    logic             req1_valid;
    logic [IDX_W-1:0] req1_src;
    logic [IDX_W-1:0] req1_dst;
    logic             req1_ready;
    logic [N_REG-1:0] oe;
    logic [N_REG-1:0] ie;
    logic             busy;
    logic             done;
    logic             done_id;
    logic             err;

    modport slave (
        input  req0_valid, req0_src, req0_dst,
        input  req1_valid, req1_src, req1_dst,
        output req0_ready, req1_ready,
        output oe, ie, busy, done, done_id, err
    );

    modport master (
        output req0_valid, req0_src, req0_dst,
        output req1_valid, req1_src, req1_dst,
        input  req0_ready, req1_ready,
        input  oe, ie, busy, done, done_id, err
    );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// Round-robin sequencer for register-to-register moves on a shared bus.
// Owns every oe/ie strobe so at most one register drives the bus.
module bus_xfer_ctrl #(
    parameter int N_REG  = 2,
    parameter int IDX_W  = 1,
    parameter int SETTLE = 1
) (
    input  logic           clk,
    input  logic           rst,
    bus_xfer_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        LATCH,
        RELEASE
    } state_t;

    localparam logic [N_REG-1:0] ONE = N_REG'(1);
    localparam logic [3:0] SET_LD = 4'(SETTLE - 1);

    state_t           state;
    logic [3:0]       cnt;
    logic [IDX_W-1:0] dst_q;
    logic             id_q;
    logic             pri1;
    logic [N_REG-1:0] oe_q;
    logic [N_REG-1:0] ie_q;
    logic             done_q;
    logic             done_id_q;
    logic             err_q;

    logic             idle;
    logic             gnt0;
    logic             gnt1;
    logic             acc;
    logic             illegal;
    logic [IDX_W-1:0] sel_src;
    logic [IDX_W-1:0] sel_dst;

    // pri1 set means req1 wins a tie (req0 was granted last)
    always_comb begin
        idle    = (state == IDLE);
        gnt1    = bus.req1_valid & (~bus.req0_valid | pri1);
        gnt0    = bus.req0_valid & ~gnt1;
        acc     = idle & (gnt0 | gnt1);
        sel_src = gnt1 ? bus.req1_src : bus.req0_src;
        sel_dst = gnt1 ? bus.req1_dst : bus.req0_dst;
        illegal = (sel_src == sel_dst)
                | (int'(sel_src) >= N_REG)
                | (int'(sel_dst) >= N_REG);
    end

    assign bus.req0_ready = idle & gnt0;
    assign bus.req1_ready = idle & gnt1;
    assign bus.busy       = ~idle;
    assign bus.oe         = oe_q;
    assign bus.ie         = ie_q;
    assign bus.done       = done_q;
    assign bus.done_id    = done_id_q;
    assign bus.err        = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            dst_q     <= '0;
            id_q      <= 1'b0;
            pri1      <= 1'b0;
            oe_q      <= '0;
            ie_q      <= '0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (acc) begin
                        dst_q <= sel_dst;
                        id_q  <= gnt1;
                        pri1  <= gnt0;
                        if (illegal) begin
                            state     <= RELEASE;
                            done_q    <= 1'b1;
                            done_id_q <= gnt1;
                            err_q     <= 1'b1;
                        end else begin
                            state <= DRIVE;
                            cnt   <= SET_LD;
                            oe_q  <= ONE << sel_src;
                        end
                    end
                end
                DRIVE: begin
                    if (cnt == 4'd0) begin
                        state <= LATCH;
                        ie_q  <= ONE << dst_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                LATCH: begin
                    state     <= RELEASE;
                    oe_q      <= '0;
                    ie_q      <= '0;
                    done_q    <= 1'b1;
                    done_id_q <= id_q;
                    err_q     <= 1'b0;
                end
                RELEASE: begin
                    state     <= IDLE;
                    done_q    <= 1'b0;
                    done_id_q <= 1'b0;
                    err_q     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
